y86_seq_controller: RTL and testbench
=====================================

Name: y86_seq_controller

Overview:
- Parametrised multi-cycle control unit for the sequential Y86-64 core.
- Replaces free-running, clock-edge stage sequencing with an explicit stage FSM.
- Owns the PC register and the architectural status register (stat).
- Issues one-cycle stage enables to the fetch/decode/execute/memory/pc_update blocks, waits on a data-memory handshake, and halts cleanly on HLT, ADR or INS.

Parameters:
- ADDR_W, 64: PC and next_pc width.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 16: maximum MEMORY-state wait cycles before an ADR fault; must be >=1.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: leave IDLE and begin fetching at the current pc.
- icode  in  4: fetched instruction code.
- instr_valid  in  1: fetch reports a legal instruction.
- imem_error  in  1: fetch address fault.
- next_pc  in  ADDR_W: pc_update result, valid during PCUPD.
- mem_ready  in  1: data memory completes the access.
- dmem_error  in  1: data memory fault, qualified by mem_ready.
- pc  out  ADDR_W: current program counter.
- fetch_en, decode_en, exec_en, wb_en, pc_en  out  1 each: stage enables.
- mem_req  out  1: data memory request; level, held until complete.
- stat  out  3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1: core stopped; sticky until rst.
- retired  out  CNT_W: count of completed instructions.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, stat=1, halted=0, retired=0, all enables and mem_req 0, wait counter 0.
- rst overrides every other input, in every state, including mid-instruction.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Each stage enable is registered and is high exactly in its own state.
- IDLE: start=1 goes to FETCH next cycle.
- FETCH checks its inputs in priority order at the end of the state:
  - imem_error: stat=3 (ADR).
  - else instr_valid=0: stat=4 (INS).
  - else icode=0: stat=2 (HLT).
  - On any of these: go to HALT, set halted=1. pc and retired stay unchanged.
  - Otherwise go to DECODE.
- DECODE goes to EXECUTE, then EXECUTE goes to MEMORY.
- MEMORY for memory icodes (4,5,8,9,A,B):
  - mem_req=1 while in the state; wait counter increments each cycle.
  - mem_ready=1 with dmem_error=0: go to WRITEBACK.
  - mem_ready=1 with dmem_error=1: stat=3, go to HALT.
  - Wait counter reaches MEM_TIMEOUT without mem_ready: stat=3, go to HALT.
  - The wait counter clears on leaving MEMORY.
- MEMORY for any other icode: one cycle, mem_req stays 0.
- WRITEBACK goes to PCUPD.
- PCUPD: pc<=next_pc, retired increments (saturating at all-ones), then go to FETCH.
- HALT is absorbing; start is ignored; only rst exits.
- Latency: 6 cycles per non-memory instruction; 5+N cycles for a memory instruction, where N = MEMORY cycles, 1..MEM_TIMEOUT.
- icode is sampled in FETCH and held internally, so the MEMORY decision does not depend on later changes of the input.

Optional Feature:
- Macro: Y86_SEQ_STEP_EN.
- When defined:
  - Extra input step (1 bit).
  - After PCUPD the FSM goes to IDLE instead of FETCH.
  - Either step=1 or start=1 in IDLE runs exactly one instruction.
- When undefined: no step port; the core free-runs from start until HALT.

Test Plan:
- Reset, start=1, icode=6, instr_valid=1, next_pc=0x0A -> fetch..pc_en each pulse once on consecutive cycles 1-6, mem_req=0, pc=0x0A after PCUPD, retired=1, stat=1.
- icode=5, mem_ready raised on the 3rd MEMORY cycle -> mem_req high for exactly 3 cycles, instruction takes 8 cycles, retired=1.
- icode=0, instr_valid=1 -> after FETCH: stat=2, halted=1, pc unchanged, retired=0; later start pulses are ignored.
- imem_error=1 with instr_valid=0 -> stat=3 (ADR wins); instr_valid=0 alone -> stat=4; decode_en never asserts in either case.
- MEM_TIMEOUT=4, icode=A, mem_ready held at 0 -> mem_req high 4 cycles, then stat=3, halted=1, mem_req=0; mem_ready=1 with dmem_error=1 also gives stat=3.
- rst asserted during EXECUTE -> next cycle: state IDLE, pc=RESET_PC, all enables 0, retired=0, stat=1.

Source files
------------

// File: rtl/y86_seq_controller.sv
// Stage-sequencing FSM for the sequential Y86-64 core; owns pc, stat and the retired count (single-step mode: Y86_SEQ_STEP_EN).
// Latency: 6 cycles per non-memory instruction, 5+N for memory instructions (N = MEMORY cycles, 1..MEM_TIMEOUT).
// Backpressure: mem_req is a level held through MEMORY until mem_ready, or until MEM_TIMEOUT expires (ADR fault).
module y86_seq_controller #(
    parameter int                ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                CNT_W       = 32,
    parameter int                MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef Y86_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              mem_ready,
    input  logic              dmem_error,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              wb_en,
    output logic              pc_en,
    output logic              mem_req,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    state_t            state;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              go;

`ifdef Y86_SEQ_STEP_EN
    assign go = start | step;
`else
    assign go = start;
`endif

    function automatic logic is_mem_icode(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Enables are registered: each is set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            stat      <= STAT_AOK;
            halted    <= 1'b0;
            retired   <= '0;
            icode_q   <= '0;
            wait_cnt  <= '0;
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            wb_en     <= 1'b0;
            pc_en     <= 1'b0;
            mem_req   <= 1'b0;
        end else begin
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            wb_en     <= 1'b0;
            pc_en     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state    <= S_FETCH;
                        fetch_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_error) begin
                        stat   <= STAT_ADR;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!instr_valid) begin
                        stat   <= STAT_INS;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (icode == 4'h0) begin
                        stat   <= STAT_HLT;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        icode_q   <= icode;
                        state     <= S_DECODE;
                        decode_en <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state   <= S_EXECUTE;
                    exec_en <= 1'b1;
                end
                S_EXECUTE: begin
                    state   <= S_MEMORY;
                    mem_req <= is_mem_icode(icode_q);
                end
                S_MEMORY: begin
                    // mem_req doubles as the "this is a memory instruction" flag here.
                    if (!mem_req) begin
                        state <= S_WRITEBACK;
                        wb_en <= 1'b1;
                    end else if (mem_ready) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        if (dmem_error) begin
                            stat   <= STAT_ADR;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_WRITEBACK;
                            wb_en <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        stat     <= STAT_ADR;
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    state <= S_PCUPD;
                    pc_en <= 1'b1;
                end
                S_PCUPD: begin
                    pc <= next_pc;
                    if (retired != '1) begin
                        retired <= retired + 1'b1;
                    end
`ifdef Y86_SEQ_STEP_EN
                    state <= S_IDLE;
`else
                    state    <= S_FETCH;
                    fetch_en <= 1'b1;
`endif
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed plus randomized bench for y86_seq_controller; expectations come from a per-instruction outcome model.
module tb_y86_seq_controller;

    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RST_PC   = 64'h100;
    localparam int          CNT_W    = 4;
    localparam int          MEM_TO   = 4;
    localparam int          CNT_MAX  = 15;

    logic              clk = 1'b0;
    logic              rst, start, instr_valid, imem_error, mem_ready, dmem_error;
    logic [3:0]        icode;
    logic [ADDR_W-1:0] next_pc, pc;
    logic              fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, halted;
    logic [2:0]        stat;
    logic [CNT_W-1:0]  retired;

    int tests = 0;
    int fails = 0;

    logic [63:0] model_pc;
    int          model_ret;

    always #5 clk = ~clk;

    y86_seq_controller #(
        .ADDR_W(ADDR_W), .RESET_PC(RST_PC), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .next_pc(next_pc), .mem_ready(mem_ready),
        .dmem_error(dmem_error), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
        .exec_en(exec_en), .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req),
        .stat(stat), .halted(halted), .retired(retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
        next_pc = '0; mem_ready = 1'b0; dmem_error = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc  = RST_PC;
        model_ret = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge where the core is in FETCH; plays one instruction and checks its outcome.
    task automatic run_instr(input logic [3:0] ic, input logic iv, input logic ie,
                             input logic [63:0] npc, input int rdy_at, input logic derr);
        int   cyc, n_mem, n_dec, n_exe, c_wb, c_pc;
        bit   done, exp_halt;
        logic [2:0] exp_stat;
        int   exp_n;
        exp_halt = 0; exp_stat = 3'd1; exp_n = 0;
        if (ie) begin exp_halt = 1; exp_stat = 3'd3; end
        else if (!iv) begin exp_halt = 1; exp_stat = 3'd4; end
        else if (ic == 4'h0) begin exp_halt = 1; exp_stat = 3'd2; end
        else if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            if (rdy_at >= 1 && rdy_at <= MEM_TO) begin
                exp_n = rdy_at;
                if (derr) begin exp_halt = 1; exp_stat = 3'd3; end
            end else begin
                exp_n = MEM_TO; exp_halt = 1; exp_stat = 3'd3;
            end
        end
        check("fetch_en_at_start", fetch_en, 1);
        icode = ic; instr_valid = iv; imem_error = ie; next_pc = npc;
        mem_ready = 1'b0; dmem_error = 1'b0;
        cyc = 1; n_mem = 0; n_dec = 0; n_exe = 0; c_wb = 0; c_pc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            icode = 4'($urandom);
            if (decode_en) n_dec++;
            if (exec_en)   n_exe++;
            if (mem_req)   n_mem++;
            if (wb_en)     c_wb = cyc;
            if (pc_en)     c_pc = cyc;
            mem_ready  = mem_req && (n_mem == rdy_at);
            dmem_error = mem_ready ? derr : 1'($urandom);
            if (pc_en || halted) done = 1;
        end
        mem_ready = 1'b0; dmem_error = 1'b0;
        check("instr_completes", done, 1);
        check("mem_cycles", n_mem, exp_n);
        check("stat", stat, exp_stat);
        check("halted", halted, exp_halt);
        if (exp_halt) begin
            check("halt_cycle", cyc, (exp_n == 0) ? 2 : 4 + exp_n);
            check("decode_count", n_dec, (exp_n == 0) ? 0 : 1);
            check("mem_req_after_halt", mem_req, 0);
            check("pc_kept", pc, model_pc);
            check("retired_kept", retired, model_ret);
        end else begin
            check("pc_en_cycle", c_pc, (exp_n == 0) ? 6 : 5 + exp_n);
            check("wb_en_cycle", c_wb, (exp_n == 0) ? 5 : 4 + exp_n);
            check("exec_count", n_exe, 1);
            @(negedge clk);
            model_pc = npc;
            if (model_ret < CNT_MAX) model_ret++;
            check("pc_updated", pc, model_pc);
            check("retired", retired, model_ret);
            check("refetch", fetch_en, 1);
        end
    endtask

    initial begin
        do_reset();
        // Reset state
        check("rst_pc", pc, RST_PC);
        check("rst_stat", stat, 1);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
        check("rst_enables", {fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req}, 0);
        @(negedge clk);
        check("idle_no_fetch", fetch_en, 0);

        // Plain ALU instruction, then a memory op answered on its 3rd MEMORY cycle
        do_start();
        run_instr(4'h6, 1, 0, 64'h0A, 0, 0);
        run_instr(4'h5, 1, 0, 64'h20, 3, 0);

        // Reset in the middle of an instruction (EXECUTE)
        icode = 4'h6;
        @(negedge clk);
        @(negedge clk);
        check("in_execute", exec_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC; model_ret = 0;
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_retired", retired, 0);
        check("mid_rst_stat", stat, 1);
        check("mid_rst_enables", {fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req}, 0);
        @(negedge clk);
        check("mid_rst_idle", fetch_en, 0);

        // HLT, then start is ignored
        do_start();
        run_instr(4'h0, 1, 0, 64'h44, 0, 0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            @(negedge clk);
            check("halt_ignores_start", {fetch_en, halted, stat}, {1'b0, 1'b1, 3'd2});
        end
        start = 1'b0;

        // ADR wins over INS; INS alone
        do_reset(); do_start();
        run_instr(4'h6, 0, 1, 64'h44, 0, 0);
        do_reset(); do_start();
        run_instr(4'h6, 0, 0, 64'h44, 0, 0);

        // Memory timeout and data-memory fault
        do_reset(); do_start();
        run_instr(4'hA, 1, 0, 64'h44, 0, 0);
        do_reset(); do_start();
        run_instr(4'h8, 1, 0, 64'h30, 1, 0);
        run_instr(4'hA, 1, 0, 64'h44, 2, 1);
        do_reset(); do_start();
        run_instr(4'hB, 1, 0, 64'h50, MEM_TO, 0);

        // Retired counter saturation
        do_reset(); do_start();
        for (int i = 0; i < CNT_MAX + 2; i++) run_instr(4'h6, 1, 0, 64'(i * 2), 0, 0);
        check("retired_saturated", retired, CNT_MAX);

        // Randomized programs
        for (int t = 0; t < 50; t++) begin
            do_reset(); do_start();
            for (int k = 0; k < 8; k++) begin
                logic [3:0] ic;
                logic       iv, ie, derr;
                int         rdy;
                ic   = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
                iv   = ($urandom_range(0, 11) != 0);
                ie   = ($urandom_range(0, 14) == 0);
                rdy  = $urandom_range(0, MEM_TO + 2);
                derr = ($urandom_range(0, 5) == 0);
                run_instr(ic, iv, ie, {$urandom, $urandom}, rdy, derr);
                if (halted) break;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
